// File: rtl/ub_pkg.sv
// ub_pkg: shared state encoding and grant level constants for the Unibus arbiter
package ub_pkg;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_SACKED = 2'd2,
      S_MASTER = 2'd3
   } state_t;
   localparam logic [2:0] LVL_NPR = 3'd0;
   localparam logic [2:0] LVL_BR4 = 3'd4;
   localparam logic [2:0] LVL_BR5 = 3'd5;
   localparam logic [2:0] LVL_BR6 = 3'd6;
   localparam logic [2:0] LVL_BR7 = 3'd7;
endpackage

// File: rtl/ub_prio_enc.sv
// ub_prio_enc: fixed-priority encoder NPR > BR7..BR4, masking BRs at or below the CPU priority
module ub_prio_enc
   import ub_pkg::*;
(
   input  logic       npr,
   input  logic [3:0] br,
   input  logic [2:0] ps_pri,
   output logic       win,
   output logic       br_elig,
   output logic [2:0] lvl
);
   logic [3:0] elig;
   logic [2:0] br_lvl;
   // mask each BR by the CPU priority, then pick the highest survivor; NPR overrides all
   always_comb begin
      for (int i = 0; i < 4; i++) elig[i] = br[i] && ((LVL_BR4 + 3'(i)) > ps_pri);
      br_lvl  = elig[3] ? LVL_BR7 : elig[2] ? LVL_BR6 : elig[1] ? LVL_BR5 : LVL_BR4;
      br_elig = |elig;
      win     = npr | br_elig;
      lvl     = npr ? LVL_NPR : br_lvl;
   end
endmodule

// File: rtl/unibus_arb.sv
// unibus_arb: Unibus NPR/BR grant arbiter with SACK handshake and grant timeout
module unibus_arb
   import ub_pkg::*;
#(
   parameter int unsigned TMO = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       npr,
   input  logic [3:0] br,
   input  logic [2:0] ps_pri,
   input  logic       cpu_bound,
   input  logic       sack,
   input  logic       bbsy,
   output logic       npg,
   output logic [3:0] bg,
   output logic       brq,
   output logic       cpu_hold,
   output logic [2:0] grant_lvl,
   output logic       tmo_err
);
   state_t     state_q, state_d;
   logic [2:0] lvl_q, lvl_d, enc_lvl;
   logic [7:0] cnt_q, cnt_d;
   logic       npg_q, npg_d, brq_q, brq_d, tmo_q, tmo_d;
   logic [3:0] bg_q, bg_d;
   logic       win, br_elig, held, stay;

   ub_prio_enc u_enc (
      .npr     (npr),
      .br      (br),
      .ps_pri  (ps_pri),
      .win     (win),
      .br_elig (br_elig),
      .lvl     (enc_lvl)
   );

   // the request that won the grant, used to detect passive release
   assign held = (lvl_q == LVL_NPR) ? npr : br[lvl_q[1:0]];

   // next state, grant level, timeout counter and registered grant lines
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         S_IDLE: if (win && (npr || cpu_bound) && !sack && !bbsy) begin
            state_d = S_GRANT;
            lvl_d   = enc_lvl;
            cnt_d   = 8'd0;
         end
         S_GRANT: begin
            cnt_d = cnt_q + 8'd1;
            if (sack) state_d = S_SACKED;
            else if (!held) state_d = S_IDLE;
            else if (cnt_q == 8'(TMO)) begin
               state_d = S_IDLE;
               tmo_d   = 1'b1;
            end
         end
         S_SACKED: if (bbsy && !sack) state_d = S_MASTER;
         default:  if (!bbsy) state_d = S_IDLE;
      endcase
      stay  = (state_q == S_GRANT) && (state_d == S_GRANT);
      npg_d = stay && (lvl_q == LVL_NPR);
      bg_d  = (stay && (lvl_q != LVL_NPR)) ? (4'b0001 << lvl_q[1:0]) : 4'b0000;
      brq_d = br_elig;
   end

   // state and output registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lvl_q   <= LVL_NPR;
         cnt_q   <= 8'd0;
         npg_q   <= 1'b0;
         bg_q    <= 4'b0000;
         brq_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         npg_q   <= npg_d;
         bg_q    <= bg_d;
         brq_q   <= brq_d;
         tmo_q   <= tmo_d;
      end
   end

   assign npg       = npg_q;
   assign bg        = bg_q;
   assign brq       = brq_q;
   assign tmo_err   = tmo_q;
   assign grant_lvl = lvl_q;
   assign cpu_hold  = (state_q == S_SACKED) || (state_q == S_MASTER) ||
                      ((state_q == S_GRANT) && (lvl_q == LVL_NPR));
endmodule
